multicycle_control: RTL
=======================

# multicycle_control

Sequencing controller for a multicycle ARMv8-subset datapath built from the team's existing ALU, RegisterFile, SignExtender, NextPCLogic and DataMemory blocks. Replaces the combinational single-cycle decoder with a Moore FSM. Per instruction it:

- steps through fetch, decode, execute, memory and writeback states;
- drives every datapath enable and mux select;
- stalls on a shared memory port acknowledge so instruction and data memories may take any number of cycles.

## Interface

Parameters:
- none

Ports:
- CLK  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instr_opcode  in  11  instruction[31:21] from memory read data, valid when mem_ack high in FETCH
- zero  in  1  ALU Zero flag
- mem_ack  in  1  memory port completion
- mem_req  out  1  memory port request (fetch or data access)
- ir_write  out  1  latch instruction register
- pc_write  out  1  update PC
- pc_branch  out  1  when pc_write: 1 = branch target, 0 = PC+4
- reg2loc, alusrc, mem2reg, regwrite, memread, memwrite  out  1 each  datapath controls, same meaning as existing single-cycle controls
- aluop  out  4  ALU control: AND 0000, ORR 0001, ADD 0010, SUB 0110, PassB 0111
- signop  out  3  SignExtender select: I 000, D 001, B 010, CB 011, MOVZ 100
- illegal  out  1  sticky undefined-opcode flag
- state  out  3  current state, for debug

## Operation

- States:
  - FETCH 000: mem_req=1, memread=1. On mem_ack: ir_write=1, pc_write=1 (pc_branch=0), opcode latched internally, go to DECODE. Without mem_ack, stay in FETCH.
  - DECODE 001: register read. Class decoded from the latched opcode. Go to EXEC; under trap config, an undefined opcode goes to HALT instead.
  - EXEC 010: aluop, alusrc, signop and reg2loc per class.
    - R-type or MOVZ: go to WB.
    - LDUR/STUR: go to MEM.
    - CBZ: pc_write=zero, pc_branch=1, go to FETCH.
    - B: pc_write=1, pc_branch=1, go to FETCH.
  - MEM 011: mem_req=1; memread for LDUR, memwrite for STUR, held until mem_ack. On ack: LDUR goes to WB, STUR goes to FETCH.
  - WB 100: regwrite=1; mem2reg=1 only for LDUR. Go to FETCH.
  - HALT 101: all enables 0; remains until reset.
- Decode, first match wins:
  - LDUR 11111000010
  - STUR 11111000000
  - ADD 10001011000
  - SUB 11001011000
  - AND 10001010000
  - ORR 10101010000
  - CBZ 10110100xxx
  - B 000101xxxxx
  - MOVZ 110100101xx
- Per-class settings:
  - R-type: alusrc=0, reg2loc=0.
  - LDUR/STUR: ADD, alusrc=1, signop D.
  - STUR/CBZ: reg2loc=1.
  - CBZ: PassB, signop CB.
  - B: signop B.
  - MOVZ: PassB, alusrc=1, signop MOVZ.
- All outputs are Moore: a function of state and the latched opcode only. zero and mem_ack only gate pc_write and transitions.

## Timing

- Reset value of every output is 0 and state is FETCH; the latched opcode resets to 0. The first mem_req is asserted the cycle after reset deasserts.
- Cycles per instruction with mem_ack returned in the same cycle as mem_req:
  - R/MOVZ: 4
  - LDUR: 5
  - STUR: 4
  - CBZ/B: 3
- Each memory wait cycle adds one cycle.
- mem_req and memread/memwrite stay stable while waiting. mem_ack outside FETCH/MEM is ignored.
- Reset mid-instruction, including mid-MEM wait, aborts immediately: no regwrite or pc_write that cycle, next state FETCH.
- CBZ samples zero in the EXEC cycle only.
- pc_write is never asserted in the same cycle as regwrite or memwrite.

## Configuration

- MC_ILLEGAL_TRAP_EN
  - Defined: an undefined opcode in DECODE goes to HALT and sets illegal=1 until reset.
  - Undefined: an undefined opcode executes as a NOP (DECODE → FETCH, no writes); illegal is tied to 0 and the HALT state is unreachable.

## Structure

- Shared package `mc_pkg` holds:
  - the state encoding enum;
  - the opcode and mask constants;
  - the aluop and signop code constants (also usable by the ALU and SignExtender benches).
- One sub-module, `mc_decode`: combinational opcode → class and control bundle. The FSM in `multicycle_control` registers state and opcode only.

## Test plan

- ADD X3,X1,X2 (opcode 10001011000), mem_ack tied high → states FETCH, DECODE, EXEC, WB; aluop=0010 and regwrite=1 only in WB; 4 cycles.
- LDUR with mem_ack delayed 3 cycles in MEM → memread and mem_req held 4 cycles; mem2reg=1 and regwrite=1 in WB; 8 cycles total.
- CBZ with zero=1 → pc_write=1, pc_branch=1, signop=011 in EXEC. Repeat with zero=0 → pc_write=0; next state FETCH in both cases.
- STUR → memwrite asserted only in MEM, reg2loc=1, never regwrite; back to FETCH after ack.
- reset asserted during a MEM wait → next cycle state=000 and all outputs 0; no memwrite on the following cycle.
- Opcode 11111111111: with MC_ILLEGAL_TRAP_EN → HALT, illegal=1 persists and mem_req=0 forever. Without it → returns to FETCH after DECODE with no writes.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle ARMv8-subset controller.
//   - state_t      FSM state encoding (also visible on the debug `state` port)
//   - op_class_t   instruction class produced by mc_decode
//   - Op*/Mask*    opcode match values and don't-care masks for instruction[31:21]
//   - Alu*/Sign*   ALU control and SignExtender select codes (reusable by those blocks' benches)
//   - exec_ctrl_t  per-class datapath control bundle
//   - moore_out_t  registered Moore outputs of the controller
package mc_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'b000,
        StDecode = 3'b001,
        StExec   = 3'b010,
        StMem    = 3'b011,
        StWb     = 3'b100,
        StHalt   = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        ClsUndef = 3'd0,
        ClsRtype = 3'd1,
        ClsLdur  = 3'd2,
        ClsStur  = 3'd3,
        ClsCbz   = 3'd4,
        ClsB     = 3'd5,
        ClsMovz  = 3'd6
    } op_class_t;

    localparam logic [10:0] MaskFull = 11'b11111111111;
    localparam logic [10:0] OpLdur   = 11'b11111000010;
    localparam logic [10:0] OpStur   = 11'b11111000000;
    localparam logic [10:0] OpAdd    = 11'b10001011000;
    localparam logic [10:0] OpSub    = 11'b11001011000;
    localparam logic [10:0] OpAnd    = 11'b10001010000;
    localparam logic [10:0] OpOrr    = 11'b10101010000;
    localparam logic [10:0] OpCbz    = 11'b10110100000;
    localparam logic [10:0] MaskCbz  = 11'b11111111000;
    localparam logic [10:0] OpB      = 11'b00010100000;
    localparam logic [10:0] MaskB    = 11'b11111100000;
    localparam logic [10:0] OpMovz   = 11'b11010010100;
    localparam logic [10:0] MaskMovz = 11'b11111111100;

    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOrr   = 4'b0001;
    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluPassB = 4'b0111;

    localparam logic [2:0] SignI    = 3'b000;
    localparam logic [2:0] SignD    = 3'b001;
    localparam logic [2:0] SignB    = 3'b010;
    localparam logic [2:0] SignCb   = 3'b011;
    localparam logic [2:0] SignMovz = 3'b100;

    typedef struct packed {
        logic [3:0] aluop;
        logic [2:0] signop;
        logic       alusrc;
        logic       reg2loc;
    } exec_ctrl_t;

    typedef struct packed {
        logic       mem_req;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       mem2reg;
        logic       pc_branch;
        exec_ctrl_t exec;
    } moore_out_t;

    function automatic logic op_match(input logic [10:0] op, input logic [10:0] value,
                                      input logic [10:0] mask);
        return (op & mask) == value;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode decoder for the multicycle controller.
// Ports:
//   opcode   in  11  latched instruction[31:21]
//   op_class out     instruction class (ClsUndef when nothing matches)
//   ctrl     out     aluop/signop/alusrc/reg2loc bundle for that class
// Patterns are tried in priority order; the first match wins.
module mc_decode
    import mc_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_t   op_class,
    output exec_ctrl_t  ctrl
);

    always_comb begin
        op_class     = ClsUndef;
        ctrl         = '0;
        ctrl.signop  = SignI;
        if (op_match(opcode, OpLdur, MaskFull)) begin
            op_class     = ClsLdur;
            ctrl.aluop   = AluAdd;
            ctrl.alusrc  = 1'b1;
            ctrl.signop  = SignD;
        end else if (op_match(opcode, OpStur, MaskFull)) begin
            op_class     = ClsStur;
            ctrl.aluop   = AluAdd;
            ctrl.alusrc  = 1'b1;
            ctrl.signop  = SignD;
            ctrl.reg2loc = 1'b1;
        end else if (op_match(opcode, OpAdd, MaskFull)) begin
            op_class     = ClsRtype;
            ctrl.aluop   = AluAdd;
        end else if (op_match(opcode, OpSub, MaskFull)) begin
            op_class     = ClsRtype;
            ctrl.aluop   = AluSub;
        end else if (op_match(opcode, OpAnd, MaskFull)) begin
            op_class     = ClsRtype;
            ctrl.aluop   = AluAnd;
        end else if (op_match(opcode, OpOrr, MaskFull)) begin
            op_class     = ClsRtype;
            ctrl.aluop   = AluOrr;
        end else if (op_match(opcode, OpCbz, MaskCbz)) begin
            op_class     = ClsCbz;
            ctrl.aluop   = AluPassB;
            ctrl.signop  = SignCb;
            ctrl.reg2loc = 1'b1;
        end else if (op_match(opcode, OpB, MaskB)) begin
            op_class     = ClsB;
            ctrl.signop  = SignB;
        end else if (op_match(opcode, OpMovz, MaskMovz)) begin
            op_class     = ClsMovz;
            ctrl.aluop   = AluPassB;
            ctrl.alusrc  = 1'b1;
            ctrl.signop  = SignMovz;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a multicycle ARMv8-subset datapath through
// FETCH, DECODE, EXEC, MEM and WB, stalling on a shared memory port acknowledge.
// Ports:
//   CLK, reset (sync, active-high)        clock and reset
//   instr_opcode[10:0]                    instruction[31:21], sampled on mem_ack in FETCH
//   zero, mem_ack                         ALU zero flag, memory completion
//   mem_req, ir_write, pc_write, pc_branch
//   reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, aluop[3:0], signop[2:0]
//   illegal                               sticky undefined-opcode flag
//   state[2:0]                            current state for debug
// Build option: define MC_ILLEGAL_TRAP_EN to send undefined opcodes to HALT and raise
// illegal; otherwise they retire as a NOP and illegal is tied low.
module multicycle_control
    import mc_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic [10:0] instr_opcode,
    input  logic        zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_branch,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t      state_q, state_d;
    logic [10:0] opcode_q, opcode_d;
    moore_out_t  out_q, out_d, out_vis;
    op_class_t   op_class;
    exec_ctrl_t  exec_ctrl;
`ifdef MC_ILLEGAL_TRAP_EN
    logic        illegal_q;
`endif

    mc_decode u_decode (
        .opcode   (opcode_q),
        .op_class (op_class),
        .ctrl     (exec_ctrl)
    );

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        unique case (state_q)
            StFetch: begin
                // mem_req is low for the first cycle after reset; an ack then is stray.
                if (out_q.mem_req && mem_ack) begin
                    opcode_d = instr_opcode;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                if (op_class == ClsUndef) begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = StHalt;
`else
                    state_d = StFetch;
`endif
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (op_class)
                    ClsLdur, ClsStur: state_d = StMem;
                    ClsRtype, ClsMovz: state_d = StWb;
                    default:           state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ack) begin
                    state_d = (op_class == ClsLdur) ? StWb : StFetch;
                end
            end
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Outputs are computed for the state being entered and registered with it. The opcode
    // only changes on the way into DECODE, so op_class is already valid for EXEC/MEM/WB.
    // The class controls are held through MEM and WB because the datapath has no ALU
    // output or store-data register: address, result and store data must stay valid.
    always_comb begin
        out_d = '0;
        case (state_d)
            StFetch: begin
                out_d.mem_req = 1'b1;
                out_d.memread = 1'b1;
            end
            StExec: begin
                out_d.exec      = exec_ctrl;
                out_d.pc_branch = (op_class == ClsCbz) || (op_class == ClsB);
            end
            StMem: begin
                out_d.exec     = exec_ctrl;
                out_d.mem_req  = 1'b1;
                out_d.memread  = (op_class == ClsLdur);
                out_d.memwrite = (op_class == ClsStur);
            end
            StWb: begin
                out_d.exec     = exec_ctrl;
                out_d.regwrite = 1'b1;
                out_d.mem2reg  = (op_class == ClsLdur);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StFetch;
            opcode_q  <= '0;
            out_q     <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            out_q     <= out_d;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= illegal_q | (state_d == StHalt);
`endif
        end
    end

    // Reset blanks every output in the cycle it is asserted, so an aborted instruction
    // cannot commit a register, memory or PC write.
    assign out_vis   = reset ? '0 : out_q;

    assign mem_req   = out_vis.mem_req;
    assign memread   = out_vis.memread;
    assign memwrite  = out_vis.memwrite;
    assign regwrite  = out_vis.regwrite;
    assign mem2reg   = out_vis.mem2reg;
    assign pc_branch = out_vis.pc_branch;
    assign aluop     = out_vis.exec.aluop;
    assign signop    = out_vis.exec.signop;
    assign alusrc    = out_vis.exec.alusrc;
    assign reg2loc   = out_vis.exec.reg2loc;

    // Only the fetch ack and the CBZ zero flag gate writes; everything else is Moore.
    assign ir_write  = !reset && (state_q == StFetch) && out_q.mem_req && mem_ack;
    assign pc_write  = ir_write ||
                       (!reset && (state_q == StExec) &&
                        ((op_class == ClsB) || ((op_class == ClsCbz) && zero)));

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal   = !reset && illegal_q;
`else
    assign illegal   = 1'b0;
`endif

    assign state     = state_q;

endmodule
